myproject_sdiv_38s_6ns_32_seq: RTL and testbench
================================================

# myproject_sdiv_38s_6ns_32_seq

Sequential signed-by-unsigned integer divider, the inverse of the generated signed×unsigned multiplier cores: a 38-bit signed dividend is divided by a 6-bit unsigned divisor to give a saturated 32-bit signed quotient and a signed remainder. The restoring algorithm retires one quotient bit per cycle. Latency is fixed regardless of operand values, so the HLS scheduler can treat the block as a constant-latency operator. It uses the same ap_start/ap_done block-level handshake as other multi-cycle operators in the design.

## Interface
- ID, 1, instance tag; no functional effect
- NUM_STAGE, 40, start-to-done latency in cycles; documentation only, must equal din0_WIDTH+2
- din0_WIDTH, 38, dividend width (signed)
- din1_WIDTH, 6, divisor width (unsigned)
- dout_WIDTH, 32, quotient width (signed)

Ports:
- ap_clk  in  1  clock, rising edge
- ap_rst_n  in  1  asynchronous active-low reset
- ap_start  in  1  request; sampled only when ap_idle=1
- ap_idle  out  1  high in IDLE; reset value 1
- ap_done  out  1  one-cycle result strobe; reset value 0
- din0  in  din0_WIDTH  dividend, two's complement, captured with ap_start
- din1  in  din1_WIDTH  divisor, unsigned, captured with ap_start
- dout  out  dout_WIDTH  quotient; reset value 0; held until next ap_done
- rem  out  din1_WIDTH+1  signed remainder; reset value 0; held until next ap_done
- ovf  out  1  quotient saturated; reset value 0; held with dout
- dbz  out  1  divisor was zero; reset value 0; held with dout

## Operation
- States: IDLE, CALC, FIX.
- IDLE with ap_start=1:
  - capture sign(din0), |din0| (din0_WIDTH-bit unsigned; |−2^37| = 2^37 fits) and din1
  - clear the partial remainder
  - load the counter with din0_WIDTH
  - go to CALC
- CALC, each cycle:
  - shift the next dividend bit (MSB first) into the partial remainder (din1_WIDTH+1 bits)
  - subtract the divisor; if the result is non-negative, keep it and shift in quotient bit 1, else shift in 0
  - decrement the counter; leave for FIX after din0_WIDTH cycles
- FIX (one cycle):
  - negate quotient magnitude and remainder if the dividend was negative
  - rounding is toward zero; the remainder takes the dividend's sign
  - saturate, register outputs, pulse ap_done, return to IDLE
- Saturation:
  - positive results with magnitude > 2^31−1 → 0x7FFFFFFF, ovf=1
  - negative results with magnitude > 2^31 → 0x80000000, ovf=1
  - −2^31 itself is not an overflow
- Divide by zero (din1=0): dbz=1, ovf=0, rem=0, dout=0x7FFFFFFF for dividend ≥ 0, 0x80000000 for dividend < 0. Full latency still applies.
- ap_start while not idle is ignored; no queueing.
- Inputs do not need to be held after the capture cycle.

## Timing
- ap_start sampled high in IDLE at edge k: CALC covers edges k+1 to k+38, FIX is at edge k+39, and ap_done plus new outputs are visible after edge k+40.
- Total latency 40 cycles; throughput 1 result per 41 cycles.
- ap_idle drops the cycle after capture and rises together with ap_done.
- ap_start high in the ap_done cycle is accepted, giving back-to-back operation at 41-cycle spacing.
- ap_done is never high for two consecutive cycles.
- ap_rst_n low at any time, including mid-CALC, forces IDLE immediately and returns every output to its reset value. The in-flight operation is discarded and no ap_done is produced.
- Reset release is synchronised by the surrounding design; the block does not rely on release timing.

## Structure
- Shared package `myproject_sdiv_pkg`:
  - state enum (IDLE/CALC/FIX)
  - saturation constants QMAX=0x7FFFFFFF, QMIN=0x80000000
  - counter width $clog2(din0_WIDTH+1)
- One sub-module: `myproject_sdiv_fix`, combinational sign-restore, saturation and divide-by-zero selection, instantiated once ahead of the output registers.
- The iteration datapath stays inline in the top module.

## Test plan
- din0=100, din1=7 → after 40 cycles dout=14, rem=2, ovf=0, dbz=0; ap_done high for exactly one cycle.
- din0=−100, din1=7 → dout=−14 (0xFFFFFFF2), rem=−2; din0=−2^31, din1=1 → dout=0x80000000, ovf=0.
- Overflow:
  - din0=2^37−1, din1=1 → dout=0x7FFFFFFF, ovf=1
  - din0=−2^37, din1=2 → dout=0x80000000, ovf=1
- din0=5, din1=0 → dout=0x7FFFFFFF, rem=0, dbz=1; din0=−5, din1=0 → dout=0x80000000, dbz=1; both still take 40 cycles.
- Control:
  - ap_start pulsed during CALC is ignored and only one ap_done appears
  - ap_start held high across ap_done gives a second result exactly 41 cycles after the first
- Reset mid-operation: ap_rst_n asserted at cycle 20 of CALC → ap_idle=1, dout/rem/ovf/dbz=0 immediately, no ap_done; a fresh 63/63 then returns dout=1, rem=0.

Source files
------------

// File: rtl/myproject_sdiv_pkg.sv
// Shared types and constants for the sequential signed-by-unsigned divider.
package myproject_sdiv_pkg;

  localparam int DIN0_W = 38;
  localparam int DIN1_W = 6;
  localparam int DOUT_W = 32;
  localparam int REM_W  = DIN1_W + 1;
  localparam int CNT_W  = $clog2(DIN0_W + 1);

  localparam logic [DOUT_W-1:0] QMAX = 32'h7FFF_FFFF;
  localparam logic [DOUT_W-1:0] QMIN = 32'h8000_0000;

  typedef enum logic [1:0] {
    IDLE,
    CALC,
    FIX
  } state_t;

endpackage

// File: rtl/myproject_sdiv_fix.sv
// Final-cycle result shaping: sign restore, saturation to 32 bits and the
// divide-by-zero substitution. Purely combinational.
module myproject_sdiv_fix
  import myproject_sdiv_pkg::*;
(
  input  logic              i_neg,
  input  logic              i_dbz,
  input  logic [DIN0_W-1:0] i_quo_mag,
  input  logic [REM_W-1:0]  i_rem_mag,
  output logic [DOUT_W-1:0] o_dout,
  output logic [REM_W-1:0]  o_rem,
  output logic              o_ovf,
  output logic              o_dbz
);

  logic w_pos_big;
  logic w_neg_big;

  // Positive results saturate above 2^31-1, negative ones only above 2^31.
  assign w_pos_big = |i_quo_mag[DIN0_W-1:DOUT_W-1];
  assign w_neg_big = (|i_quo_mag[DIN0_W-1:DOUT_W]) |
                     (i_quo_mag[DOUT_W-1] & (|i_quo_mag[DOUT_W-2:0]));

  // NOTE: every output gets a default before the branches so no path leaves
  // a value unassigned, which would otherwise infer a latch.
  always_comb begin
    o_dout = QMAX;
    o_rem  = '0;
    o_ovf  = 1'b0;
    o_dbz  = i_dbz;
    if (i_dbz) begin
      o_dout = i_neg ? QMIN : QMAX;
    end else if (!i_neg) begin
      o_rem = i_rem_mag;
      if (w_pos_big) o_ovf  = 1'b1;
      else           o_dout = i_quo_mag[DOUT_W-1:0];
    end else begin
      o_rem = -i_rem_mag;
      if (w_neg_big) begin
        o_dout = QMIN;
        o_ovf  = 1'b1;
      end else begin
        o_dout = -i_quo_mag[DOUT_W-1:0];
      end
    end
  end

endmodule

// File: rtl/myproject_sdiv_38s_6ns_32_seq.sv
// Constant-latency restoring divider: 38-bit signed dividend by 6-bit unsigned
// divisor, saturated 32-bit signed quotient, ap_start/ap_done handshake.
module myproject_sdiv_38s_6ns_32_seq
  import myproject_sdiv_pkg::*;
#(
  parameter int ID         = 1,
  parameter int NUM_STAGE  = 40,
  parameter int din0_WIDTH = DIN0_W,
  parameter int din1_WIDTH = DIN1_W,
  parameter int dout_WIDTH = DOUT_W
) (
  input  logic                  ap_clk,
  input  logic                  ap_rst_n,
  input  logic                  ap_start,
  output logic                  ap_idle,
  output logic                  ap_done,
  input  logic [din0_WIDTH-1:0] din0,
  input  logic [din1_WIDTH-1:0] din1,
  output logic [dout_WIDTH-1:0] dout,
  output logic [din1_WIDTH:0]   rem,
  output logic                  ovf,
  output logic                  dbz
);

  // Iteration count is the dividend width, which is two less than the latency.
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(NUM_STAGE - 2);

  state_t                r_state;
  logic                  r_idle, r_done, r_neg;
  logic [DIN0_W-1:0]     r_dvd, r_quo;
  logic [DIN1_W-1:0]     r_dvs;
  logic [REM_W-1:0]      r_prem;
  logic [CNT_W-1:0]      r_cnt;
  logic [DOUT_W-1:0]     r_dout;
  logic [REM_W-1:0]      r_rem;
  logic                  r_ovf, r_dbz;

  logic [DIN0_W-1:0]     w_abs;
  logic [REM_W:0]        w_shift;
  logic [REM_W+1:0]      w_diff;
  logic                  w_sub_ok;
  logic [REM_W-1:0]      w_prem_next;
  logic [DOUT_W-1:0]     w_dout;
  logic [REM_W-1:0]      w_rem;
  logic                  w_ovf, w_dbz;

  // |-2^37| wraps to bit 37 alone, which is correct as an unsigned magnitude.
  assign w_abs       = din0[din0_WIDTH-1] ? (~din0 + 1'b1) : din0;
  assign w_shift     = {r_prem, r_dvd[DIN0_W-1]};
  assign w_diff      = {1'b0, w_shift} - {3'b000, r_dvs};
  assign w_sub_ok    = ~w_diff[REM_W+1];
  assign w_prem_next = REM_W'(w_sub_ok ? w_diff[REM_W:0] : w_shift);

  myproject_sdiv_fix u_fix (
    .i_neg     (r_neg),
    .i_dbz     (r_dvs == '0),
    .i_quo_mag (r_quo),
    .i_rem_mag (r_prem),
    .o_dout    (w_dout),
    .o_rem     (w_rem),
    .o_ovf     (w_ovf),
    .o_dbz     (w_dbz)
  );

  // NOTE: all state here uses non-blocking assignments so every register
  // samples pre-edge values, independent of statement order.
  always_ff @(posedge ap_clk or negedge ap_rst_n) begin
    if (!ap_rst_n) begin
      r_state <= IDLE;
      r_idle  <= 1'b1;
      r_done  <= 1'b0;
      r_neg   <= 1'b0;
      r_dvd   <= '0;
      r_quo   <= '0;
      r_dvs   <= '0;
      r_prem  <= '0;
      r_cnt   <= '0;
      r_dout  <= '0;
      r_rem   <= '0;
      r_ovf   <= 1'b0;
      r_dbz   <= 1'b0;
    end else begin
      r_done <= 1'b0;
      unique case (r_state)
        IDLE: begin
          if (ap_start) begin
            r_neg   <= din0[din0_WIDTH-1];
            r_dvd   <= w_abs;
            r_dvs   <= din1;
            r_prem  <= '0;
            r_quo   <= '0;
            r_cnt   <= CNT_LOAD;
            r_idle  <= 1'b0;
            r_state <= CALC;
          end
        end
        CALC: begin
          // The extra cycle at count zero keeps latency at exactly NUM_STAGE.
          if (r_cnt != '0) begin
            r_prem <= w_prem_next;
            r_quo  <= {r_quo[DIN0_W-2:0], w_sub_ok};
            r_dvd  <= r_dvd << 1;
            r_cnt  <= r_cnt - 1'b1;
          end else begin
            r_state <= FIX;
          end
        end
        FIX: begin
          r_dout  <= w_dout;
          r_rem   <= w_rem;
          r_ovf   <= w_ovf;
          r_dbz   <= w_dbz;
          r_done  <= 1'b1;
          r_idle  <= 1'b1;
          r_state <= IDLE;
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign ap_idle = r_idle;
  assign ap_done = r_done;
  assign dout    = r_dout;
  assign rem     = r_rem;
  assign ovf     = r_ovf;
  assign dbz     = r_dbz;

endmodule

// File: tb/tb_myproject_sdiv_38s_6ns_32_seq.sv
// Directed-vector bench for the sequential divider: results, latency,
// handshake behaviour and mid-operation reset.
module tb_myproject_sdiv_38s_6ns_32_seq;

  logic        ap_clk = 1'b0;
  logic        ap_rst_n = 1'b0;
  logic        ap_start = 1'b0;
  logic        ap_idle, ap_done;
  logic [37:0] din0 = '0;
  logic [5:0]  din1 = '0;
  logic [31:0] dout;
  logic [6:0]  rem;
  logic        ovf, dbz;

  int n_vec = 0;
  int n_err = 0;

  always #5 ap_clk = ~ap_clk;

  myproject_sdiv_38s_6ns_32_seq dut (
    .ap_clk   (ap_clk),
    .ap_rst_n (ap_rst_n),
    .ap_start (ap_start),
    .ap_idle  (ap_idle),
    .ap_done  (ap_done),
    .din0     (din0),
    .din1     (din1),
    .dout     (dout),
    .rem      (rem),
    .ovf      (ovf),
    .dbz      (dbz)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic check_outputs(input string tag, input logic [31:0] e_q, input logic [6:0] e_r,
                               input logic e_ovf, input logic e_dbz);
    check({tag, ".dout"}, 64'(dout), 64'(e_q));
    check({tag, ".rem"},  64'(rem),  64'(e_r));
    check({tag, ".ovf"},  64'(ovf),  64'(e_ovf));
    check({tag, ".dbz"},  64'(dbz),  64'(e_dbz));
  endtask

  // Issue one division, scramble the inputs after capture, then time ap_done.
  task automatic run_div(input string tag, input logic [37:0] a, input logic [5:0] b,
                         input logic [31:0] e_q, input logic [6:0] e_r,
                         input logic e_ovf, input logic e_dbz);
    int n;
    @(negedge ap_clk);
    din0 = a; din1 = b; ap_start = 1'b1;
    @(posedge ap_clk); #1;
    ap_start = 1'b0; din0 = ~a; din1 = ~b;
    check({tag, ".idle_drop"}, 64'(ap_idle), 64'd0);
    n = 0;
    do begin
      @(posedge ap_clk); #1;
      n++;
    end while (!ap_done && n < 100);
    check({tag, ".latency"}, 64'(n), 64'd40);
    check({tag, ".idle_rise"}, 64'(ap_idle), 64'd1);
    check_outputs(tag, e_q, e_r, e_ovf, e_dbz);
    @(posedge ap_clk); #1;
    check({tag, ".done_one_cycle"}, 64'(ap_done), 64'd0);
  endtask

  initial begin
    int dones, first_done, second_done;
    logic [31:0] q_first, q_second;

    repeat (3) @(posedge ap_clk);
    #1;
    check("reset.idle", 64'(ap_idle), 64'd1);
    check("reset.done", 64'(ap_done), 64'd0);
    check_outputs("reset", 32'h0, 7'h0, 1'b0, 1'b0);
    @(negedge ap_clk);
    ap_rst_n = 1'b1;

    run_div("p100_7",     38'd100,            6'd7,  32'd14,          7'd2,   1'b0, 1'b0);
    run_div("n100_7",     -38'sd100,          6'd7,  32'hFFFF_FFF2,   7'h7E,  1'b0, 1'b0);
    run_div("n2p31_1",    38'h3F_8000_0000,   6'd1,  32'h8000_0000,   7'h0,   1'b0, 1'b0);
    run_div("pmax_1",     38'h1F_FFFF_FFFF,   6'd1,  32'h7FFF_FFFF,   7'h0,   1'b1, 1'b0);
    run_div("nmin_2",     38'h20_0000_0000,   6'd2,  32'h8000_0000,   7'h0,   1'b1, 1'b0);
    run_div("p2p32_2",    38'h01_0000_0000,   6'd2,  32'h7FFF_FFFF,   7'h0,   1'b1, 1'b0);
    run_div("n2p32_2",    38'h3F_0000_0000,   6'd2,  32'h8000_0000,   7'h0,   1'b0, 1'b0);
    run_div("p1000_63",   38'd1000,           6'd63, 32'd15,          7'd55,  1'b0, 1'b0);
    run_div("n1000_63",   -38'sd1000,         6'd63, 32'hFFFF_FFF1,   7'h49,  1'b0, 1'b0);
    run_div("p5_0",       38'd5,              6'd0,  32'h7FFF_FFFF,   7'h0,   1'b0, 1'b1);
    run_div("n5_0",       -38'sd5,            6'd0,  32'h8000_0000,   7'h0,   1'b0, 1'b1);

    // ap_start pulsed mid-CALC with different operands must be ignored.
    @(negedge ap_clk);
    din0 = 38'd100; din1 = 6'd7; ap_start = 1'b1;
    @(posedge ap_clk); #1;
    ap_start = 1'b0;
    dones = 0; first_done = 0; q_first = '0;
    for (int i = 1; i <= 90; i++) begin
      @(posedge ap_clk); #1;
      if (ap_done) begin
        dones++;
        if (dones == 1) begin first_done = i; q_first = dout; end
      end
      if (i == 10) begin ap_start = 1'b1; din0 = 38'd7; din1 = 6'd1; end
      if (i == 11) ap_start = 1'b0;
    end
    check("ignore.done_count", 64'(dones), 64'd1);
    check("ignore.done_cycle", 64'(first_done), 64'd40);
    check("ignore.dout", 64'(q_first), 64'd14);

    // ap_start held across ap_done: second capture on the done cycle.
    @(negedge ap_clk);
    din0 = 38'd100; din1 = 6'd7; ap_start = 1'b1;
    @(posedge ap_clk); #1;
    dones = 0; first_done = 0; second_done = 0; q_first = '0; q_second = '0;
    for (int i = 1; i <= 95; i++) begin
      @(posedge ap_clk); #1;
      if (ap_done) begin
        dones++;
        if (dones == 1) begin first_done = i; q_first = dout; din0 = 38'd63; din1 = 6'd63; end
        if (dones == 2) begin second_done = i; q_second = dout; end
      end
      if (i == first_done + 1 && dones == 1) ap_start = 1'b0;
    end
    ap_start = 1'b0;
    check("b2b.done_count", 64'(dones), 64'd2);
    check("b2b.first_cycle", 64'(first_done), 64'd40);
    check("b2b.spacing", 64'(second_done - first_done), 64'd41);
    check("b2b.first_dout", 64'(q_first), 64'd14);
    check("b2b.second_dout", 64'(q_second), 64'd1);

    // Reset at CALC cycle 20: outputs clear at once, no ap_done afterwards.
    run_div("pre_rst", 38'd1000, 6'd63, 32'd15, 7'd55, 1'b0, 1'b0);
    @(negedge ap_clk);
    din0 = 38'd100; din1 = 6'd7; ap_start = 1'b1;
    @(posedge ap_clk); #1;
    ap_start = 1'b0;
    repeat (20) @(posedge ap_clk);
    #1;
    ap_rst_n = 1'b0;
    #1;
    check("midrst.idle", 64'(ap_idle), 64'd1);
    check("midrst.done", 64'(ap_done), 64'd0);
    check_outputs("midrst", 32'h0, 7'h0, 1'b0, 1'b0);
    repeat (2) @(negedge ap_clk);
    ap_rst_n = 1'b1;
    dones = 0;
    for (int i = 0; i < 50; i++) begin
      @(posedge ap_clk); #1;
      if (ap_done) dones++;
    end
    check("midrst.no_done", 64'(dones), 64'd0);
    run_div("p63_63", 38'd63, 6'd63, 32'd1, 7'd0, 1'b0, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
